pim_dram_scheduler: RTL

- Shares the single-bank DRAM model among the PIM units. Each PIM unit is a requester.
- Round-robin arbitration picks one row access at a time.
- Sequences the DDR3 command stream for that access (PRE/ACT/RD/WR) under an open-page policy, enforcing tRP, tRCD, tCL, burst length and tWR.
- Issues commands and the row address only. The 65536-bit row data path stays in the DRAM model.

---
 rtl/pim_dram_scheduler.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/pim_dram_scheduler.sv
// Round-robin scheduler sharing one DRAM bank among PIM requesters.
// Emits the PRE/ACT/RD/WR command stream under an open-page policy.
module pim_dram_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int ADDRESS_LEN = 10,
    parameter int NUM_ROWS    = 100,
    parameter int TRCD_CYCLES = 8,
    parameter int TCL_CYCLES  = 8,
    parameter int TRP_CYCLES  = 8,
    parameter int TWR_CYCLES  = 7,
    parameter int BURST_LEN   = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDRESS_LEN-1:0] req_addr,
    output logic [NUM_REQ-1:0]             gnt,
    output logic [NUM_REQ-1:0]             done,
    output logic                           err,
    output logic                           cmd_act,
    output logic                           cmd_pre,
    output logic                           cmd_rd,
    output logic                           cmd_wr,
    output logic [ADDRESS_LEN-1:0]         cmd_row,
    output logic                           busy
);

    localparam int RD_WAIT  = TCL_CYCLES + BURST_LEN;
    localparam int WR_WAIT  = BURST_LEN + TWR_CYCLES;
    localparam int MAX_A    = (TRP_CYCLES > TRCD_CYCLES) ? TRP_CYCLES : TRCD_CYCLES;
    localparam int MAX_B    = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int MAX_WAIT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);
    localparam int IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE, PRE, ACT, RD, WR, WAIT_RD, WAIT_WR, FIN
    } state_e;

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [IDX_W-1:0]       ptr_q, own_q;
    logic                   we_q;
    logic [ADDRESS_LEN-1:0] addr_q;
    logic [ADDRESS_LEN-1:0] open_row_q;
    logic                   open_vld_q;

    logic [NUM_REQ-1:0]     gnt_q, done_q;
    logic                   err_q, act_q, pre_q, rd_q, wr_q, busy_q;
    logic [ADDRESS_LEN-1:0] row_q;

    logic                   win_vld, win_we, win_ill;
    logic [IDX_W-1:0]       win_idx, ptr_d;
    logic [ADDRESS_LEN-1:0] win_addr;

    always_comb begin
        int unsigned j;
        j        = 0;
        win_vld  = 1'b0;
        win_idx  = '0;
        win_we   = 1'b0;
        win_addr = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            j = (32'(ptr_q) + k) % NUM_REQ;
            if (!win_vld && req[j]) begin
                win_vld  = 1'b1;
                win_idx  = IDX_W'(j);
                win_we   = req_we[j];
                win_addr = req_addr[j*ADDRESS_LEN +: ADDRESS_LEN];
            end
        end
        win_ill = (32'(win_addr) >= 32'(NUM_ROWS));
        ptr_d   = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    // The done cycle (FIN, or IDLE after a rejected request) also arbitrates,
    // so a waiting requester is granted in the very next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            own_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            open_row_q <= '0;
            open_vld_q <= 1'b0;
            gnt_q      <= '0;
            done_q     <= '0;
            err_q      <= 1'b0;
            act_q      <= 1'b0;
            pre_q      <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            row_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            gnt_q  <= '0;
            done_q <= '0;
            err_q  <= 1'b0;
            act_q  <= 1'b0;
            pre_q  <= 1'b0;
            rd_q   <= 1'b0;
            wr_q   <= 1'b0;
            row_q  <= '0;
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            case (state_q)
                IDLE, FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                    if (win_vld) begin
                        gnt_q[win_idx] <= 1'b1;
                        busy_q         <= 1'b1;
                        ptr_q          <= ptr_d;
                        own_q          <= win_idx;
                        we_q           <= win_we;
                        addr_q         <= win_addr;
                        if (win_ill) begin
                            done_q[win_idx] <= 1'b1;
                            err_q           <= 1'b1;
                        end else if (open_vld_q && open_row_q == win_addr) begin
                            row_q <= win_addr;
                            if (win_we) begin
                                wr_q    <= 1'b1;
                                cnt_q   <= CNT_W'(WR_WAIT - 1);
                                state_q <= WR;
                            end else begin
                                rd_q    <= 1'b1;
                                cnt_q   <= CNT_W'(RD_WAIT - 1);
                                state_q <= RD;
                            end
                        end else if (open_vld_q) begin
                            pre_q      <= 1'b1;
                            row_q      <= open_row_q;
                            open_vld_q <= 1'b0;
                            cnt_q      <= CNT_W'(TRP_CYCLES - 1);
                            state_q    <= PRE;
                        end else begin
                            act_q      <= 1'b1;
                            row_q      <= win_addr;
                            open_row_q <= win_addr;
                            open_vld_q <= 1'b1;
                            cnt_q      <= CNT_W'(TRCD_CYCLES - 1);
                            state_q    <= ACT;
                        end
                    end
                end
                PRE: if (cnt_q == '0) begin
                    act_q      <= 1'b1;
                    row_q      <= addr_q;
                    open_row_q <= addr_q;
                    open_vld_q <= 1'b1;
                    cnt_q      <= CNT_W'(TRCD_CYCLES - 1);
                    state_q    <= ACT;
                end
                ACT: if (cnt_q == '0) begin
                    row_q <= addr_q;
                    if (we_q) begin
                        wr_q    <= 1'b1;
                        cnt_q   <= CNT_W'(WR_WAIT - 1);
                        state_q <= WR;
                    end else begin
                        rd_q    <= 1'b1;
                        cnt_q   <= CNT_W'(RD_WAIT - 1);
                        state_q <= RD;
                    end
                end
                RD, WAIT_RD: begin
                    if (cnt_q == '0) begin
                        done_q[own_q] <= 1'b1;
                        state_q       <= FIN;
                    end else begin
                        state_q <= WAIT_RD;
                    end
                end
                WR, WAIT_WR: begin
                    if (cnt_q == '0) begin
                        done_q[own_q] <= 1'b1;
                        state_q       <= FIN;
                    end else begin
                        state_q <= WAIT_WR;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign err     = err_q;
    assign cmd_act = act_q;
    assign cmd_pre = pre_q;
    assign cmd_rd  = rd_q;
    assign cmd_wr  = wr_q;
    assign cmd_row = row_q;
    assign busy    = busy_q;

endmodule
